mem_arbiter: RTL

Single-port memory arbiter for the HYmips core. Merges the core's instruction-fetch port (`inst_ce`/`pc`/`inst`) and data port (`mem_ce`/`mem_we`/`mem_maddr`/`mem_msel`/`mem_mdata`/`mdata_mem`) onto one shared SRAM bus with a req/ack handshake. Raises a stall request into `ctrl` until every pending access of the current cycle has completed. Sits between the top-level core ports and the board SRAM controller.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter that merges
// the core's fetch and data ports onto one req/ack bus.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_BUSY = 2'd1,
        ST_I_BUSY = 2'd2
    } arb_state_t;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;
    localparam logic [3:0]  SEL_WORD        = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Merges instruction fetch and data accesses onto one SRAM bus (data first),
// stalling the core until every access requested this cycle has completed.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ce,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_ce,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        stall_o,
    output logic        sram_req,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [3:0]  sram_sel,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ack,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYC);

    arb_state_t  r_state;
    logic        r_d_done;
    logic        r_i_done;
    logic [7:0]  r_wait_cnt;

    logic        w_d_pend;
    logic        w_i_pend;
    logic        w_release;
    logic        w_ack;
    logic        w_complete;
    logic [31:0] w_rdata;

    assign w_d_pend   = d_ce & ~r_d_done;
    assign w_i_pend   = i_ce & ~r_i_done;
    assign stall_o    = w_d_pend | w_i_pend;
    // The core retires its instruction on this edge; its ce inputs are stale.
    assign w_release  = (r_d_done | r_i_done) & ~stall_o;
    assign w_ack      = sram_req & sram_ack;
    assign w_complete = w_ack | (sram_req & (r_wait_cnt == TIMEOUT_LIMIT));
    assign w_rdata    = w_ack ? sram_rdata : 32'h0;

    // NOTE: all state here uses non-blocking assignments so every branch reads
    // the pre-edge values; blocking writes would make later reads order-dependent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_d_done   <= 1'b0;
            r_i_done   <= 1'b0;
            r_wait_cnt <= 8'h0;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= 32'h0;
            sram_sel   <= 4'h0;
            sram_wdata <= 32'h0;
            i_rdata    <= 32'h0;
            d_rdata    <= 32'h0;
            bus_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_release) begin
                        r_d_done <= 1'b0;
                        r_i_done <= 1'b0;
                    end else if (w_d_pend) begin
                        sram_req   <= 1'b1;
                        sram_we    <= d_we;
                        sram_addr  <= d_addr;
                        sram_sel   <= d_sel;
                        sram_wdata <= d_wdata;
                        r_wait_cnt <= 8'h0;
                        r_state    <= ST_D_BUSY;
                    end else if (w_i_pend) begin
                        sram_req   <= 1'b1;
                        sram_we    <= 1'b0;
                        sram_addr  <= i_addr;
                        sram_sel   <= SEL_WORD;
                        r_wait_cnt <= 8'h0;
                        r_state    <= ST_I_BUSY;
                    end
                end

                ST_D_BUSY: begin
                    if (w_complete) begin
                        r_d_done <= 1'b1;
                        if (!sram_we)
                            d_rdata <= w_rdata;
                        if (!w_ack)
                            bus_err <= 1'b1;
                        // Chain straight into the fetch without dropping req.
                        if (w_i_pend) begin
                            sram_we    <= 1'b0;
                            sram_addr  <= i_addr;
                            sram_sel   <= SEL_WORD;
                            r_wait_cnt <= 8'h0;
                            r_state    <= ST_I_BUSY;
                        end else begin
                            sram_req <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                ST_I_BUSY: begin
                    if (w_complete) begin
                        r_i_done <= 1'b1;
                        i_rdata  <= w_rdata;
                        if (!w_ack)
                            bus_err <= 1'b1;
                        if (w_d_pend) begin
                            sram_we    <= d_we;
                            sram_addr  <= d_addr;
                            sram_sel   <= d_sel;
                            sram_wdata <= d_wdata;
                            r_wait_cnt <= 8'h0;
                            r_state    <= ST_D_BUSY;
                        end else begin
                            sram_req <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                default: begin
                    sram_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
